bmem_frame_scaler: RTL
======================

Name: bmem_frame_scaler

Overview:
Streams a small processed image out of block memory (the NN input image, IMG_W x IMG_H) as a full OUT_W x OUT_H raster, one pixel per clock, into the SDRAM frame-buffer write path.
- Each source pixel is upscaled nearest-neighbour by SCALE and placed at (X_OFF, Y_OFF); every other raster pixel is border fill.
- Successor to the fixed 28x28 memory-to-VGA reader, adding:
  - generic geometry and data width
  - pixel modes: pass, invert, threshold
  - continuous re-streaming
  - queued restart requests

Parameters:
IMG_W, 28, source image width in pixels
IMG_H, 28, source image height in pixels
SCALE, 16, integer upscale factor (>=1; not restricted to powers of two)
OUT_W, 640, output raster width
OUT_H, 480, output raster height
X_OFF, 96, first output column of the image window
Y_OFF, 16, first output row of the image window
DATA_W, 12, pixel and memory data width
ADDR_W, 11, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
iCLK  in  1  pixel clock
iRST_N  in  1  asynchronous active-low reset
iDONE  in  1  single-cycle pulse: memory image complete, request one frame
iCONT  in  1  1 = restart automatically after each frame
iMODE  in  2  0 pass, 1 invert, 2 threshold, 3 reserved (behaves as pass)
iTHRESH  in  DATA_W  threshold level for mode 2
iBORDER  in  DATA_W  fill value outside the image window
oREN  out  1  memory read enable
oADDR  out  ADDR_W  memory read address
iDATA  in  DATA_W  memory read data, valid 1 cycle after oREN
oDATA  out  DATA_W  output pixel
oDVAL  out  1  output pixel valid
oBUSY  out  1  frame in progress
oFRAME_CNT  out  16  frames completed, wraps at 16'hFFFF -> 0

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and pending flag cleared. Reset mid-frame aborts the frame immediately; no further oDVAL until the next iDONE.
- States:
  - IDLE: waits for iDONE. iDONE -> RUN.
  - RUN: raster counters x in 0..OUT_W-1 and y in 0..OUT_H-1 step once per cycle, x fastest.
  - DRAIN: flushes the 2-stage pipeline.
  - Exit from DRAIN: go to RUN if a request is pending or iCONT=1, else IDLE.
- oBUSY = 1 in RUN and DRAIN.
- Window test: inside = X_OFF <= x < X_OFF+IMG_W*SCALE and Y_OFF <= y < Y_OFF+IMG_H*SCALE.
- Source address, no divider:
  - sub-counters sx_sub and sy_sub count 0..SCALE-1 and advance sx and sy.
  - row_base advances by IMG_W when sy advances.
  - oADDR = row_base + sx.
- oREN = 1 only for cycles in RUN with inside = 1.
- Pipeline, fixed 2-cycle latency from counter cycle to oDATA/oDVAL:
  - stage 1 carries inside and valid.
  - stage 2 registers the output.
  - Source for stage 2 is iDATA when inside, otherwise iBORDER.
- Exactly OUT_W*OUT_H contiguous oDVAL pulses per frame, no gaps. Back-to-back frames are also gap-free: the next frame's first counter cycle overlaps DRAIN.
- Modes apply to in-window pixels only; border is never transformed:
  - invert: oDATA = ~iDATA.
  - threshold: oDATA = all-ones if iDATA >= iTHRESH, else 0.
  - iMODE, iTHRESH and iBORDER are sampled per pixel; changes take effect on the next pixel.
- oFRAME_CNT increments in the cycle the last pixel's oDVAL is asserted.
- iDONE during RUN or DRAIN sets a single pending flag. Further pulses do not accumulate. The flag is cleared when the new frame starts.
- iDONE coinciding with the exit from DRAIN starts the next frame, with no lost request.
- Boundaries:
  - SCALE=1 and X_OFF=Y_OFF=0 with IMG=OUT is a straight copy.
  - The window must lie within OUT (checked by an assertion, not handled in RTL).

Test Plan:
Bench parameters unless stated: IMG_W=4, IMG_H=2, SCALE=2, OUT_W=12, OUT_H=6, X_OFF=2, Y_OFF=1, DATA_W=8; memory word[a] = 8'h10+a; iBORDER=8'h00.
1. Pass mode, single iDONE:
   - 72 consecutive oDVAL pulses.
   - row 0 all 00.
   - rows 1-2 read 00 00 10 10 11 11 12 12 13 13 00 00.
   - rows 3-4 same pattern on 14..17.
   - row 5 all 00.
   - first oDVAL 2 cycles after RUN entry; oFRAME_CNT=1; return to IDLE.
2. Mode 1: in-window pixel 8'h10 -> 8'hEF, border stays 00. Mode 2 with iTHRESH=8'h14: words 10..13 -> 00, words 14..17 -> FF.
3. iDONE pulsed twice during RUN -> exactly one extra frame follows back-to-back, no oDVAL gap between frames; oFRAME_CNT ends at 2.
4. iCONT=1 -> frames repeat indefinitely. oFRAME_CNT preloaded near 16'hFFFF wraps from FFFF to 0000.
5. iRST_N asserted at pixel 30 -> all outputs 0 immediately, state IDLE. After release, no activity until iDONE; next frame is complete and correct.
6. SCALE=1, IMG_W=OUT_W=4, IMG_H=OUT_H=2, offsets 0 -> output 10..17 in order; oREN high for all 8 counter cycles.

Source files
------------

// File: rtl/bmem_frame_scaler_if.sv
// Bus bundle for bmem_frame_scaler: frame control, block-memory read port and pixel output.
// The master view belongs to the scaler; the slave view belongs to memory and the frame-buffer side.
interface bmem_frame_scaler_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 11
);
  logic              iDONE;
  logic              iCONT;
  logic [1:0]        iMODE;
  logic [DATA_W-1:0] iTHRESH;
  logic [DATA_W-1:0] iBORDER;
  logic              oREN;
  logic [ADDR_W-1:0] oADDR;
  logic [DATA_W-1:0] iDATA;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic              oBUSY;
  logic [15:0]       oFRAME_CNT;

  modport master (
    input  iDONE, iCONT, iMODE, iTHRESH, iBORDER, iDATA,
    output oREN, oADDR, oDATA, oDVAL, oBUSY, oFRAME_CNT
  );

  modport slave (
    output iDONE, iCONT, iMODE, iTHRESH, iBORDER, iDATA,
    input  oREN, oADDR, oDATA, oDVAL, oBUSY, oFRAME_CNT
  );
endinterface

// File: rtl/bmem_frame_scaler.sv
// Streams a block-memory image as a full raster: nearest-neighbour upscale by SCALE at
// (X_OFF, Y_OFF), border fill elsewhere, one pixel per clock with a fixed 2-cycle latency.
module bmem_frame_scaler #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned SCALE  = 16,
  parameter int unsigned OUT_W  = 640,
  parameter int unsigned OUT_H  = 480,
  parameter int unsigned X_OFF  = 96,
  parameter int unsigned Y_OFF  = 16,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 11
) (
  input logic                 iCLK,
  input logic                 iRST_N,
  bmem_frame_scaler_if.master bus
);

  localparam int unsigned XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned SXW   = $clog2(IMG_W + 1);
  localparam int unsigned SUBW  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned X_END = X_OFF + IMG_W * SCALE;
  localparam int unsigned Y_END = Y_OFF + IMG_H * SCALE;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  if ((X_END > OUT_W) || (Y_END > OUT_H) || (SCALE < 1)) begin : g_bad_window
    $error("bmem_frame_scaler: image window does not fit in the output raster");
  end
  if ((64'd1 << ADDR_W) < 64'(IMG_W * IMG_H)) begin : g_bad_addr
    $error("bmem_frame_scaler: ADDR_W too small for IMG_W*IMG_H");
  end

  logic [1:0]        r_state, w_state;
  logic              r_drain, w_drain;
  logic              r_pend, w_pend;
  logic [XW-1:0]     r_x, w_x;
  logic [YW-1:0]     r_y, w_y;
  logic              r_in_x, w_in_x;
  logic              r_in_y, w_in_y;
  logic [SUBW-1:0]   r_sx_sub, w_sx_sub;
  logic [SXW-1:0]    r_sx, w_sx;
  logic [SUBW-1:0]   r_sy_sub, w_sy_sub;
  logic [ADDR_W-1:0] r_row_base, w_row_base;
  logic              r_s1_val, r_s1_in, r_s1_last;
  logic              r_dval;
  logic [DATA_W-1:0] r_data, w_pix;
  logic [15:0]       r_frame_cnt;

  logic        w_run, w_x_last, w_y_last, w_frame_end, w_restart, w_start, w_inside;
  int unsigned w_x_inc, w_y_inc;

  assign w_run       = (r_state == ST_RUN);
  assign w_x_last    = (r_x == XW'(OUT_W - 1));
  assign w_y_last    = (r_y == YW'(OUT_H - 1));
  assign w_frame_end = w_run & w_x_last & w_y_last;
  assign w_restart   = r_pend | bus.iCONT | bus.iDONE;
  assign w_inside    = r_in_x & r_in_y;
  assign w_x_inc     = 32'(r_x) + 32'd1;
  assign w_y_inc     = 32'(r_y) + 32'd1;

  // A restart decided on the last counter cycle keeps RUN, so back-to-back frames have no gap.
  always_comb begin
    w_state = r_state;
    w_drain = r_drain;
    case (r_state)
      ST_IDLE:  if (bus.iDONE) w_state = ST_RUN;
      ST_RUN: begin
        if (w_frame_end && !w_restart) begin
          w_state = ST_DRAIN;
          w_drain = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (r_drain) w_state = w_restart ? ST_RUN : ST_IDLE;
        else         w_drain = 1'b1;
      end
      default:  w_state = ST_IDLE;
    endcase
    w_start = ((r_state != ST_RUN) && (w_state == ST_RUN)) || (w_frame_end && w_restart);
    w_pend  = w_start ? 1'b0 : (r_pend | (bus.iDONE & (r_state != ST_IDLE)));
  end

  // Raster and source-address counters; sub-counters replace a divide by SCALE.
  always_comb begin
    w_x        = r_x;
    w_y        = r_y;
    w_in_x     = r_in_x;
    w_in_y     = r_in_y;
    w_sx       = r_sx;
    w_sx_sub   = r_sx_sub;
    w_sy_sub   = r_sy_sub;
    w_row_base = r_row_base;
    if (w_run) begin
      if (w_x_last) begin
        w_x      = '0;
        w_in_x   = (X_OFF == 0);
        w_sx     = '0;
        w_sx_sub = '0;
        if (w_y_last) begin
          w_y        = '0;
          w_in_y     = (Y_OFF == 0);
          w_sy_sub   = '0;
          w_row_base = '0;
        end else begin
          w_y = r_y + YW'(1);
          if (w_y_inc == Y_OFF)      w_in_y = 1'b1;
          else if (w_y_inc == Y_END) w_in_y = 1'b0;
          if (r_in_y) begin
            if (r_sy_sub == SUBW'(SCALE - 1)) begin
              w_sy_sub   = '0;
              w_row_base = r_row_base + ADDR_W'(IMG_W);
            end else begin
              w_sy_sub = r_sy_sub + SUBW'(1);
            end
          end
        end
      end else begin
        w_x = r_x + XW'(1);
        if (w_x_inc == X_OFF)      w_in_x = 1'b1;
        else if (w_x_inc == X_END) w_in_x = 1'b0;
        if (r_in_x) begin
          if (r_sx_sub == SUBW'(SCALE - 1)) begin
            w_sx_sub = '0;
            w_sx     = r_sx + SXW'(1);
          end else begin
            w_sx_sub = r_sx_sub + SUBW'(1);
          end
        end
      end
    end
  end

  // Pixel transform applies to in-window data only; border passes through untouched.
  always_comb begin
    w_pix = bus.iBORDER;
    if (r_s1_in) begin
      case (bus.iMODE)
        2'd1:    w_pix = ~bus.iDATA;
        2'd2:    w_pix = (bus.iDATA >= bus.iTHRESH) ? '1 : '0;
        default: w_pix = bus.iDATA;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= ST_IDLE;
      r_drain     <= 1'b0;
      r_pend      <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_in_x      <= (X_OFF == 0);
      r_in_y      <= (Y_OFF == 0);
      r_sx        <= '0;
      r_sx_sub    <= '0;
      r_sy_sub    <= '0;
      r_row_base  <= '0;
      r_s1_val    <= 1'b0;
      r_s1_in     <= 1'b0;
      r_s1_last   <= 1'b0;
      r_dval      <= 1'b0;
      r_data      <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state    <= w_state;
      r_drain    <= w_drain;
      r_pend     <= w_pend;
      r_x        <= w_x;
      r_y        <= w_y;
      r_in_x     <= w_in_x;
      r_in_y     <= w_in_y;
      r_sx       <= w_sx;
      r_sx_sub   <= w_sx_sub;
      r_sy_sub   <= w_sy_sub;
      r_row_base <= w_row_base;
      r_s1_val   <= w_run;
      r_s1_in    <= w_inside;
      r_s1_last  <= w_frame_end;
      r_dval     <= r_s1_val;
      if (r_s1_val)  r_data      <= w_pix;
      if (r_s1_last) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.oREN       = w_run & w_inside;
  assign bus.oADDR      = r_row_base + ADDR_W'(r_sx);
  assign bus.oDATA      = r_data;
  assign bus.oDVAL      = r_dval;
  assign bus.oBUSY      = (r_state != ST_IDLE);
  assign bus.oFRAME_CNT = r_frame_cnt;

endmodule
